// File: rtl/pipeline_types.sv
// Shared decode-pipeline types: bit-decoder output record and capture-stage state encoding.
package pipeline_types;

   typedef struct packed {
      logic valid;
      logic decode_bit;
      logic treset;
   } shift_reg_input_t;

   typedef enum logic [0:0] {
      CAP_CAPTURE  = 1'b0,
      CAP_PASSTHRU = 1'b1
   } capture_state_t;

   localparam int MAX_BITS_PER_PIXEL = 32;

endpackage

// File: rtl/pixel_bit_assembler.sv
// Serial-to-parallel assembler for one pixel word; word/word_done show the value including
// the bit being shifted this cycle so the caller can latch on the same edge.
module pixel_bit_assembler
   import pipeline_types::*;
#(
   parameter int BITS_PER_PIXEL = 24,
   parameter bit MSB_FIRST      = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      shift_en,
   input  logic                      bit_in,
   input  logic                      clear,
   output logic [BITS_PER_PIXEL-1:0] word,
   output logic                      word_done,
   output logic                      partial
);

   localparam int BW = $clog2(BITS_PER_PIXEL);

   logic [BITS_PER_PIXEL-1:0] shift_r;
   logic [BITS_PER_PIXEL-1:0] shift_s;
   logic [BW-1:0]             bit_cnt_r;

   // Shift contents with the incoming bit applied
   always_comb begin
      shift_s = shift_r;
      if (MSB_FIRST) begin
         shift_s = {shift_r[BITS_PER_PIXEL-2:0], bit_in};
      end else begin
         shift_s = {bit_in, shift_r[BITS_PER_PIXEL-1:1]};
      end
   end

   assign word      = shift_s;
   assign word_done = shift_en && !clear && (bit_cnt_r == BW'(BITS_PER_PIXEL - 1));
   assign partial   = (bit_cnt_r != {BW{1'b0}});

   // Shift register and bit counter; clear has priority over a simultaneous shift
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shift_r   <= {BITS_PER_PIXEL{1'b0}};
         bit_cnt_r <= {BW{1'b0}};
      end else if (clear) begin
         shift_r   <= {BITS_PER_PIXEL{1'b0}};
         bit_cnt_r <= {BW{1'b0}};
      end else if (shift_en) begin
         shift_r   <= shift_s;
         bit_cnt_r <= word_done ? {BW{1'b0}} : (bit_cnt_r + BW'(1));
      end
   end

endmodule

// File: rtl/led_frame_capture.sv
// Captures NUM_PIXELS decoded words into a holding register, then passes the stream
// through until the next treset.
module led_frame_capture
   import pipeline_types::*;
#(
   parameter int BITS_PER_PIXEL = 24,
   parameter int NUM_PIXELS     = 1,
   parameter bit MSB_FIRST      = 1'b1,
   localparam int CW            = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic                                 i_clk,
   input  logic                                 i_reset_n,
   input  shift_reg_input_t                     i_shift_reg,
   output logic [NUM_PIXELS*BITS_PER_PIXEL-1:0] o_pixel_data,
   output logic                                 o_pixel_valid,
   output logic [CW-1:0]                        o_pixel_index,
   output logic                                 o_frame_done,
   output logic                                 o_passthru_en,
   output logic                                 o_short_frame
);

   localparam int          BPP      = BITS_PER_PIXEL;
   localparam int          DW       = NUM_PIXELS * BITS_PER_PIXEL;
   localparam logic [CW-1:0] LAST_PIX = CW'(NUM_PIXELS - 1);

   capture_state_t state_r, state_s;
   logic [CW-1:0]  pix_cnt_r, pix_cnt_s;
   logic [CW-1:0]  pixel_index_r, pixel_index_s;
   logic [DW-1:0]  pixel_data_r, pixel_data_s;
   logic           pixel_valid_r, pixel_valid_s;
   logic           frame_done_r, frame_done_s;
   logic           short_frame_r, short_frame_s;
   logic           passthru_en_r;
   logic [BPP-1:0] word_s;
   logic           word_done_s;
   logic           partial_s;
   logic           shift_en_s;

   assign shift_en_s = i_shift_reg.valid && (state_r == CAP_CAPTURE);

   pixel_bit_assembler #(
      .BITS_PER_PIXEL (BITS_PER_PIXEL),
      .MSB_FIRST      (MSB_FIRST)
   ) u_assembler (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .shift_en  (shift_en_s),
      .bit_in    (i_shift_reg.decode_bit),
      .clear     (i_shift_reg.treset),
      .word      (word_s),
      .word_done (word_done_s),
      .partial   (partial_s)
   );

   // FSM next state, pixel counter and pulse decode
   always_comb begin
      state_s       = state_r;
      pix_cnt_s     = pix_cnt_r;
      pixel_index_s = pixel_index_r;
      pixel_valid_s = 1'b0;
      frame_done_s  = 1'b0;
      short_frame_s = 1'b0;
      case (state_r)
         CAP_CAPTURE: begin
            if (i_shift_reg.treset) begin
               pix_cnt_s     = {CW{1'b0}};
               short_frame_s = partial_s || (pix_cnt_r != {CW{1'b0}});
            end else if (word_done_s) begin
               pixel_valid_s = 1'b1;
               pixel_index_s = pix_cnt_r;
               if (pix_cnt_r == LAST_PIX) begin
                  frame_done_s = 1'b1;
                  pix_cnt_s    = {CW{1'b0}};
                  state_s      = CAP_PASSTHRU;
               end else begin
                  pix_cnt_s = pix_cnt_r + CW'(1);
               end
            end else begin
               pix_cnt_s = pix_cnt_r;
            end
         end
         CAP_PASSTHRU: begin
            if (i_shift_reg.treset) begin
               state_s   = CAP_CAPTURE;
               pix_cnt_s = {CW{1'b0}};
            end else begin
               state_s = CAP_PASSTHRU;
            end
         end
         default: begin
            state_s   = CAP_CAPTURE;
            pix_cnt_s = {CW{1'b0}};
         end
      endcase
   end

   // Holding array: only the slot addressed by pix_cnt takes a completed word
   always_comb begin
      pixel_data_s = pixel_data_r;
      for (int k = 0; k < NUM_PIXELS; k++) begin
         if (word_done_s && (pix_cnt_r == CW'(k))) begin
            pixel_data_s[k*BPP +: BPP] = word_s;
         end else begin
            pixel_data_s[k*BPP +: BPP] = pixel_data_r[k*BPP +: BPP];
         end
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r <= CAP_CAPTURE;
      end else begin
         state_r <= state_s;
      end
   end

   // Counter, holding array and registered outputs
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pix_cnt_r     <= {CW{1'b0}};
         pixel_index_r <= {CW{1'b0}};
         pixel_data_r  <= {DW{1'b0}};
         pixel_valid_r <= 1'b0;
         frame_done_r  <= 1'b0;
         short_frame_r <= 1'b0;
         passthru_en_r <= 1'b0;
      end else begin
         pix_cnt_r     <= pix_cnt_s;
         pixel_index_r <= pixel_index_s;
         pixel_data_r  <= pixel_data_s;
         pixel_valid_r <= pixel_valid_s;
         frame_done_r  <= frame_done_s;
         short_frame_r <= short_frame_s;
         passthru_en_r <= (state_s == CAP_PASSTHRU);
      end
   end

   assign o_pixel_data  = pixel_data_r;
   assign o_pixel_valid = pixel_valid_r;
   assign o_pixel_index = pixel_index_r;
   assign o_frame_done  = frame_done_r;
   assign o_passthru_en = passthru_en_r;
   assign o_short_frame = short_frame_r;

endmodule
